// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan of N_DIGITS common-anode digits through one shared decoder
//   clk, reset (async, active-high); en scan enable; load/digits_in new score codes;
//   lz_blank leading-zero blanking; code_out shared decoder code; an_n active-low digit enables;
//   digit_idx scanned digit; frame_done end-of-frame pulse; upd_ack new-data-active pulse.
module seg_scan_ctrl #(
  parameter int N_DIGITS  = 4,
  parameter int IDX_W     = 2,
  parameter int DWELL     = 50000,
  parameter int BLANK_CYC = 500,
  parameter int CNT_W     = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  load,
  input  logic [N_DIGITS*4-1:0] digits_in,
  input  logic                  lz_blank,
  output logic [3:0]            code_out,
  output logic [N_DIGITS-1:0]   an_n,
  output logic [IDX_W-1:0]      digit_idx,
  output logic                  frame_done,
  output logic                  upd_ack
);
  typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_t;
  localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC > 0 ? BLANK_CYC - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);
  localparam logic [N_DIGITS*4-1:0] ZEROS = {N_DIGITS{4'b0001}};
  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [N_DIGITS*4-1:0] act_q, act_d, pend_q, pend_d;
  logic                  pflag_q, pflag_d;
  logic [3:0]            code_q, code_d;
  logic [N_DIGITS-1:0]   an_q, an_d, lz_mask;
  logic                  fd_q, fd_d, ack_q, ack_d;
  logic                  adv, boundary, above;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      act_q   <= ZEROS;
      pend_q  <= ZEROS;
      pflag_q <= 1'b0;
      code_q  <= 4'b0001;
      an_q    <= '1;
      fd_q    <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      act_q   <= act_d;
      pend_q  <= pend_d;
      pflag_q <= pflag_d;
      code_q  <= code_d;
      an_q    <= an_d;
      fd_q    <= fd_d;
      ack_q   <= ack_d;
    end
  end
  // With no blanking gap the end of a dwell is itself the advance step.
  always_comb begin
    adv = (state_q == SHOW && cnt_q == SHOW_LAST && BLANK_CYC == 0) ||
          (state_q == BLANK && cnt_q == BLANK_LAST);
    boundary = en && adv && idx_q == IDX_LAST;
    state_d = state_q;
    idx_d = idx_q;
    cnt_d = '0;
    if (!en) begin
      state_d = IDLE;
      idx_d = '0;
    end else if (state_q == IDLE) begin
      state_d = SHOW;
      idx_d = '0;
    end else if (adv) begin
      state_d = SHOW;
      idx_d = boundary ? '0 : idx_q + 1'b1;
    end else if (state_q == SHOW && cnt_q == SHOW_LAST) begin
      state_d = BLANK;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end
  // The boundary consumes the pending set from before this edge; a coincident load re-arms it.
  always_comb begin
    act_d = act_q;
    pend_d = pend_q;
    pflag_d = pflag_q;
    fd_d = boundary;
    ack_d = 1'b0;
    if (boundary && pflag_q) begin
      act_d = pend_q;
      pflag_d = 1'b0;
      ack_d = 1'b1;
    end
    if (load && state_q == IDLE) begin
      act_d = digits_in;
      ack_d = 1'b1;
    end else if (load) begin
      pend_d = digits_in;
      pflag_d = 1'b1;
    end
  end
  // above tracks whether this digit and every higher digit hold the numeral-0 code.
  always_comb begin
    above = 1'b1;
    lz_mask = '0;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      above = above && act_d[k*4 +: 4] == 4'b0001;
      lz_mask[k] = lz_blank && k != 0 && above;
    end
    an_d = '1;
    if (state_d == SHOW && !lz_mask[idx_d]) an_d[idx_d] = 1'b0;
    code_d = state_d == SHOW ? act_d[idx_d*4 +: 4] : code_q;
  end
  assign code_out = code_q;
  assign an_n = an_q;
  assign digit_idx = idx_q;
  assign frame_done = fd_q;
  assign upd_ack = ack_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: randomized and directed checks of seg_scan_ctrl against a timeline model
module tb_seg_scan_ctrl;
  localparam int N = 4, DW = 4, BL = 2, SLOT = DW + BL, PER = N * SLOT, PER2 = N * DW;
  logic clk = 1'b0, reset = 1'b0, en = 1'b0, load = 1'b0, lz = 1'b0;
  logic [15:0] din = '0;
  logic [3:0] code, an, code2, an2;
  logic [1:0] idx, idx2;
  logic fd, ack, fd2, ack2;
  int checks = 0, errors = 0;
  bit run, run2, m_pf, e_fd, e_ack;
  int t, t2;
  logic [3:0] m_act[N], m_pend[N];
  logic [3:0] e_code;

  seg_scan_ctrl #(.N_DIGITS(N), .IDX_W(2), .DWELL(DW), .BLANK_CYC(BL), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .en(en), .load(load), .digits_in(din), .lz_blank(lz),
    .code_out(code), .an_n(an), .digit_idx(idx), .frame_done(fd), .upd_ack(ack));

  seg_scan_ctrl #(.N_DIGITS(N), .IDX_W(2), .DWELL(DW), .BLANK_CYC(0), .CNT_W(4)) dut2 (
    .clk(clk), .reset(reset), .en(1'b1), .load(1'b0), .digits_in(16'h1111), .lz_blank(1'b0),
    .code_out(code2), .an_n(an2), .digit_idx(idx2), .frame_done(fd2), .upd_ack(ack2));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit blanked(input int dg, input bit z);
    if (!z || dg == 0) return 1'b0;
    for (int k = dg; k < N; k++) if (m_act[k] != 4'b0001) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    run = 0; t = 0; run2 = 0; t2 = 0; m_pf = 0; e_fd = 0; e_ack = 0; e_code = 4'b0001;
    for (int k = 0; k < N; k++) begin m_act[k] = 4'b0001; m_pend[k] = 4'b0001; end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    chk("rst_an", an, 4'hF);
    chk("rst_code", code, 4'b0001);
    chk("rst_idx", idx, 0);
    chk("rst_fd", fd, 0);
    chk("rst_ack", ack, 0);
    chk("rst_an2", an2, 4'hF);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Drive one cycle, advance the model across the edge, then compare all outputs.
  task automatic step(input bit e, input bit l, input logic [15:0] d, input bit z);
    int p, dg, p2;
    logic [3:0] e_an, e_an2;
    logic [1:0] e_idx;
    en = e; load = l; din = d; lz = z;
    @(posedge clk);
    e_fd = 0; e_ack = 0;
    if (!run) begin
      if (l) begin
        for (int k = 0; k < N; k++) m_act[k] = d[k*4 +: 4];
        e_ack = 1;
      end
      if (e) begin run = 1; t = 0; end
    end else if (!e) begin
      run = 0;
      if (l) begin for (int k = 0; k < N; k++) m_pend[k] = d[k*4 +: 4]; m_pf = 1; end
    end else begin
      t++;
      if (t % PER == 0) begin
        e_fd = 1;
        if (m_pf) begin m_act = m_pend; m_pf = 0; e_ack = 1; end
      end
      if (l) begin for (int k = 0; k < N; k++) m_pend[k] = d[k*4 +: 4]; m_pf = 1; end
    end
    e_an = 4'hF;
    e_idx = 0;
    if (run) begin
      p = t % PER;
      dg = p / SLOT;
      e_idx = 2'(dg);
      if (p % SLOT < DW) begin
        e_code = m_act[dg];
        if (!blanked(dg, z)) e_an[dg] = 1'b0;
      end
    end
    if (!run2) begin run2 = 1; t2 = 0; end else t2++;
    p2 = t2 % PER2;
    e_an2 = 4'hF;
    e_an2[p2 / DW] = 1'b0;
    #1;
    load = 1'b0;
    chk("an_n", an, e_an);
    chk("code_out", code, e_code);
    chk("digit_idx", idx, e_idx);
    chk("frame_done", fd, e_fd);
    chk("upd_ack", ack, e_ack);
    chk("nogap_an_n", an2, e_an2);
    chk("nogap_idx", idx2, p2 / DW);
    chk("nogap_frame_done", fd2, t2 > 0 && p2 == 0);
    chk("nogap_code", code2, 4'b0001);
    chk("nogap_ack", ack2, 0);
  endtask

  task automatic run_n(input int n, input bit z);
    for (int i = 0; i < n; i++) step(1, 0, 16'h0, z);
  endtask

  initial begin
    logic [15:0] rd;
    bit z;
    model_reset();
    do_reset();
    step(0, 0, 16'h0, 0);
    step(0, 0, 16'h0, 0);
    step(1, 0, 16'h0, 0);
    chk("first_show_an", an, 4'b1110);
    run_n(52, 0);
    step(0, 0, 16'h0, 0);
    step(0, 1, 16'h5432, 0);
    step(0, 0, 16'h0, 0);
    run_n(30, 0);
    step(1, 1, 16'h2222, 0);
    run_n(3, 0);
    step(1, 1, 16'h3333, 0);
    run_n(40, 0);
    step(0, 0, 16'h0, 0);
    step(0, 1, 16'h1121, 1);
    run_n(30, 1);
    step(0, 1, 16'h1111, 1);
    run_n(30, 1);
    for (int i = 0; i < 100 && !(run && (t % PER) / SLOT == 2 && (t % PER) % SLOT == 1); i++)
      step(1, 0, 16'h0, 0);
    step(0, 0, 16'h0, 0);
    chk("drop_en_an", an, 4'hF);
    chk("drop_en_idx", idx, 0);
    run_n(30, 0);
    step(1, 1, 16'h6789, 0);
    for (int i = 0; i < 100 && (t + 1) % PER != 0; i++) step(1, 0, 16'h0, 0);
    step(1, 1, 16'h4444, 0);
    run_n(30, 0);
    step(1, 1, 16'h9999, 0);
    for (int i = 0; i < 100 && (t % PER) % SLOT < DW; i++) step(1, 0, 16'h0, 0);
    do_reset();
    run_n(60, 0);
    z = 0;
    for (int i = 0; i < 1500; i++) begin
      if (i % 150 == 0) z = $urandom_range(0, 1) == 1;
      for (int k = 0; k < N; k++) rd[k*4 +: 4] = $urandom_range(0, 2) == 0 ? 4'($urandom) : 4'b0001;
      step($urandom_range(0, 59) != 0, $urandom_range(0, 11) == 0, rd, z);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
